// File: rtl/operand_read_stage_pkg.sv
// Risky ISA definitions shared by the operand read stage:
// default widths, immediate field sizes, opcode codes and the per-opcode
// usage classification (which sources are read, whether a GPR is written,
// which immediate field is meaningful).
package operand_read_stage_pkg;

  localparam int DATA_SIZE        = 32;
  localparam int ADDRESS_SIZE     = 16;
  localparam int INSTRUCTION_SIZE = 32;
  localparam int GPR_SIZE         = 4;

  localparam int OPCODE_SIZE    = 5;
  localparam int VALUE_SIZE     = 5;
  localparam int CONSTANT_SIZE  = 16;
  localparam int OFFSET_SIZE    = 16;
  localparam int CONDITION_SIZE = 3;

  localparam logic [OPCODE_SIZE-1:0] OP_NOP   = 5'd0;
  localparam logic [OPCODE_SIZE-1:0] OP_ADD   = 5'd1;
  localparam logic [OPCODE_SIZE-1:0] OP_SUB   = 5'd2;
  localparam logic [OPCODE_SIZE-1:0] OP_AND   = 5'd3;
  localparam logic [OPCODE_SIZE-1:0] OP_OR    = 5'd4;
  localparam logic [OPCODE_SIZE-1:0] OP_XOR   = 5'd5;
  localparam logic [OPCODE_SIZE-1:0] OP_SHL   = 5'd6;
  localparam logic [OPCODE_SIZE-1:0] OP_SHR   = 5'd7;
  localparam logic [OPCODE_SIZE-1:0] OP_LOADC = 5'd8;
  localparam logic [OPCODE_SIZE-1:0] OP_LOAD  = 5'd9;
  localparam logic [OPCODE_SIZE-1:0] OP_STORE = 5'd10;
  localparam logic [OPCODE_SIZE-1:0] OP_JUMP  = 5'd11;

  // Source usage: none, SRC_A only, or SRC_A and SRC_B.
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_A = 2'd1, SRC_AB = 2'd2} src_use_e;

  // Which immediate field an opcode carries.
  typedef enum logic [1:0] {IMM_NONE = 2'd0, IMM_VALUE = 2'd1, IMM_CONST = 2'd2, IMM_JUMP = 2'd3} imm_use_e;

  typedef struct packed {
    logic     legal;
    src_use_e src;
    logic     dst_wr;
    imm_use_e imm;
  } op_class_t;

  // Opcodes outside the table classify as all-zero: illegal, reads nothing, writes nothing.
  function automatic op_class_t classify(input logic [OPCODE_SIZE-1:0] op);
    op_class_t c;
    c = '0;
    case (op)
      OP_NOP:                              c.legal = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: c = '{legal: 1'b1, src: SRC_AB,   dst_wr: 1'b1, imm: IMM_NONE};
      OP_SHL, OP_SHR:                      c = '{legal: 1'b1, src: SRC_A,    dst_wr: 1'b1, imm: IMM_VALUE};
      OP_LOADC:                            c = '{legal: 1'b1, src: SRC_NONE, dst_wr: 1'b1, imm: IMM_CONST};
      OP_LOAD:                             c = '{legal: 1'b1, src: SRC_A,    dst_wr: 1'b1, imm: IMM_NONE};
      OP_STORE:                            c = '{legal: 1'b1, src: SRC_AB,   dst_wr: 1'b0, imm: IMM_NONE};
      OP_JUMP:                             c = '{legal: 1'b1, src: SRC_A,    dst_wr: 1'b0, imm: IMM_JUMP};
      default:                             c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/operand_read_stage_read_hazard_unit.sv
// read_hazard_unit: per-source RAW comparator against the EX and WB stages.
// Raises the hazard flag and selects the operand value. Purely combinational.
// Optional forwarding is enabled with the READ_BYPASS_EN macro.
module read_hazard_unit
  import operand_read_stage_pkg::*;
#(
  parameter int DATA_W = DATA_SIZE,
  parameter int GPR_W  = GPR_SIZE
) (
  input  logic              used,
  input  logic [GPR_W-1:0]  addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [GPR_W-1:0]  ex_dest,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              wb_wr_en,
  input  logic [GPR_W-1:0]  wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              hazard,
  output logic [DATA_W-1:0] operand
);

  logic ex_hit, wb_hit;

  // An unused source never matches, so it can neither stall nor be forwarded.
  assign ex_hit = used && ex_wr_en && (ex_dest == addr);
  assign wb_hit = used && wb_wr_en && (wb_dest == addr);

`ifdef READ_BYPASS_EN
  // Only a load in EX has no data yet; everything else is forwarded.
  assign hazard = ex_hit && ex_is_load;

  // EX is younger than WB, so it wins when both match.
  always_comb begin
    if (!used)                     operand = '0;
    else if (ex_hit && !ex_is_load) operand = ex_data;
    else if (wb_hit)               operand = wb_data;
    else                           operand = rf_data;
  end
`else
  logic unused_fwd;

  // Without forwarding any in-flight producer must retire before the read.
  assign hazard     = ex_hit || wb_hit;
  assign operand    = used ? rf_data : '0;
  assign unused_fwd = ^{ex_is_load, ex_data, wb_data};
`endif

endmodule

// File: rtl/operand_read_stage.sv
// operand_read_stage: Risky decode / register-read stage.
// Decodes in_instr, drives the register-file read ports, checks RAW hazards
// per source (read_hazard_unit), registers the bundle behind valid/ready,
// flushes on jump and counts hazard-stall cycles (saturating).
// Optional feature macro: READ_BYPASS_EN (EX/WB operand forwarding).
module operand_read_stage
  import operand_read_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_SIZE,
  parameter int ADDR_W   = ADDRESS_SIZE,
  parameter int INSTR_W  = INSTRUCTION_SIZE,
  parameter int GPR_W    = GPR_SIZE,
  parameter int STALL_CW = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_pc,
  input  logic [INSTR_W-1:0]        in_instr,
  output logic [GPR_W-1:0]          rf_addr0,
  output logic [GPR_W-1:0]          rf_addr1,
  input  logic [DATA_W-1:0]         rf_data0,
  input  logic [DATA_W-1:0]         rf_data1,
  input  logic                      ex_wr_en,
  input  logic                      ex_is_load,
  input  logic [GPR_W-1:0]          ex_dest,
  input  logic [DATA_W-1:0]         ex_data,
  input  logic                      wb_wr_en,
  input  logic [GPR_W-1:0]          wb_dest,
  input  logic [DATA_W-1:0]         wb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPCODE_SIZE-1:0]    out_opcode,
  output logic [GPR_W-1:0]          out_dest,
  output logic                      out_dest_wr,
  output logic [DATA_W-1:0]         out_operand0,
  output logic [DATA_W-1:0]         out_operand1,
  output logic [VALUE_SIZE-1:0]     out_value,
  output logic [CONSTANT_SIZE-1:0]  out_constant,
  output logic [OFFSET_SIZE-1:0]    out_offset,
  output logic [CONDITION_SIZE-1:0] out_condition,
  output logic [ADDR_W-1:0]         out_pc,
  output logic [STALL_CW-1:0]       stall_count
);

  // Field map: opcode at the top, then DST, SRC_A, SRC_B; COND shares DST
  // (jumps write no GPR); VALUE/CONST/OFFSET sit at the bottom.
  localparam int OPC_MSB  = INSTR_W - 1;
  localparam int DST_MSB  = OPC_MSB - OPCODE_SIZE;
  localparam int SRCA_MSB = DST_MSB - GPR_W;
  localparam int SRCB_MSB = SRCA_MSB - GPR_W;
  localparam int COND_MSB = DST_MSB;

  localparam logic [STALL_CW-1:0] STALL_ONE = STALL_CW'(1);

  typedef struct packed {
    logic [OPCODE_SIZE-1:0]    opcode;
    logic [GPR_W-1:0]          dest;
    logic                      dest_wr;
    logic [1:0][DATA_W-1:0]    operand;
    logic [VALUE_SIZE-1:0]     value;
    logic [CONSTANT_SIZE-1:0]  constant;
    logic [OFFSET_SIZE-1:0]    offset;
    logic [CONDITION_SIZE-1:0] condition;
    logic [ADDR_W-1:0]         pc;
  } bundle_t;

  op_class_t                cls;
  logic [OPCODE_SIZE-1:0]   opcode;
  logic [1:0]               src_used;
  logic [1:0][GPR_W-1:0]    src_addr;
  logic [1:0][DATA_W-1:0]   rd_data;
  logic [1:0][DATA_W-1:0]   operand;
  logic [1:0]               src_hazard;
  logic                     hazard, busy, accept;
  bundle_t                  dec, bundle;

  assign opcode = in_instr[OPC_MSB -: OPCODE_SIZE];
  assign cls    = classify(opcode);

  // Source selection: unused sources read address 0.
  always_comb begin
    src_used[0] = (cls.src != SRC_NONE);
    src_used[1] = (cls.src == SRC_AB);
    src_addr[0] = src_used[0] ? in_instr[SRCA_MSB -: GPR_W] : '0;
    src_addr[1] = src_used[1] ? in_instr[SRCB_MSB -: GPR_W] : '0;
  end

  assign rf_addr0   = src_addr[0];
  assign rf_addr1   = src_addr[1];
  assign rd_data[0] = rf_data0;
  assign rd_data[1] = rf_data1;

  for (genvar i = 0; i < 2; i++) begin : g_src
    read_hazard_unit #(.DATA_W(DATA_W), .GPR_W(GPR_W)) u_hazard (
      .used       (src_used[i]),
      .addr       (src_addr[i]),
      .rf_data    (rd_data[i]),
      .ex_wr_en   (ex_wr_en),
      .ex_is_load (ex_is_load),
      .ex_dest    (ex_dest),
      .ex_data    (ex_data),
      .wb_wr_en   (wb_wr_en),
      .wb_dest    (wb_dest),
      .wb_data    (wb_data),
      .hazard     (src_hazard[i]),
      .operand    (operand[i])
    );
  end

  // Assemble the decoded bundle; fields an opcode does not carry stay zero.
  always_comb begin
    dec         = '0;
    dec.opcode  = cls.legal ? opcode : OP_NOP;
    dec.dest_wr = cls.dst_wr;
    if (cls.dst_wr) dec.dest = in_instr[DST_MSB -: GPR_W];
    dec.operand = operand;
    case (cls.imm)
      IMM_VALUE: dec.value    = in_instr[VALUE_SIZE-1:0];
      IMM_CONST: dec.constant = in_instr[CONSTANT_SIZE-1:0];
      IMM_JUMP: begin
        dec.offset    = in_instr[OFFSET_SIZE-1:0];
        dec.condition = in_instr[COND_MSB -: CONDITION_SIZE];
      end
      default: ;
    endcase
    dec.pc = in_pc;
  end

  assign hazard   = |src_hazard;
  assign busy     = out_valid && !out_ready;
  assign in_ready = !busy && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Output register: flush clears, a stalled consumer holds, otherwise load or bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      bundle    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      bundle    <= '0;
    end else if (!busy) begin
      out_valid <= accept;
      bundle    <= accept ? dec : '0;
    end
  end

  // Saturating count of cycles an offered instruction waits on a hazard.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (in_valid && hazard && !flush && !(&stall_count))
      stall_count <= stall_count + STALL_ONE;
  end

  assign out_opcode    = bundle.opcode;
  assign out_dest      = bundle.dest;
  assign out_dest_wr   = bundle.dest_wr;
  assign out_operand0  = bundle.operand[0];
  assign out_operand1  = bundle.operand[1];
  assign out_value     = bundle.value;
  assign out_constant  = bundle.constant;
  assign out_offset    = bundle.offset;
  assign out_condition = bundle.condition;
  assign out_pc        = bundle.pc;

endmodule
